// File: rtl/rem_pkg.sv
// Shared definitions for the word serializer and its downstream mod-3 remainder FSM.
package rem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLR   = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  localparam logic [1:0] REM0        = 2'b00;
  localparam logic [1:0] REM1        = 2'b01;
  localparam logic [1:0] REM2        = 2'b10;
  localparam logic [1:0] REM_ILLEGAL = 2'b11;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register; MSB presented first, zeros shifted in at the LSB.
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] sreg_q, sreg_d;

  always_comb begin
    sreg_d = sreg_q;
    if (load_i) begin
      sreg_d = data_i;
    end else if (shift_i) begin
      sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign msb_o = sreg_q[WIDTH-1];

endmodule

// File: rtl/word_bit_serializer.sv
// Feeds a word MSB-first into a serial mod-3 remainder FSM and returns word plus remainder.
module word_bit_serializer
  import rem_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             word_clr,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic [1:0]       rem_in,
  output logic             rem_valid,
  output logic [1:0]       rem_out,
  output logic [WIDTH-1:0] word_out,
  output logic             rem_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q;
  logic             in_ready_q, word_clr_q, bit_out_q, bit_valid_q;
  logic             rem_valid_q, rem_err_q;
  logic [1:0]       rem_out_q;
  logic [WIDTH-1:0] word_out_q;
  logic             accept, last_bit, piso_msb, shift_en;

  assign accept   = (state_q == ST_IDLE) && in_valid && in_ready_q;
  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
  // The shifter also advances on the CLR->SHIFT edge so bit_out_q can be registered.
  assign shift_en = (state_d == ST_SHIFT);

  piso_shift_reg #(.WIDTH(WIDTH)) u_piso (
    .clk     (clk),
    .rst_n_i (reset_n),
    .load_i  (accept),
    .shift_i (shift_en),
    .data_i  (in_data),
    .msb_o   (piso_msb)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_CLR;
          cnt_d   = '0;
        end
      end
      ST_CLR:   state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (last_bit) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q      <= '0;
      in_ready_q  <= 1'b0;
      word_clr_q  <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      rem_valid_q <= 1'b0;
      rem_out_q   <= '0;
      word_out_q  <= '0;
      rem_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        word_q <= in_data;
      end
      in_ready_q  <= (state_d == ST_IDLE);
      word_clr_q  <= (state_d == ST_CLR);
      bit_valid_q <= shift_en;
      bit_out_q   <= shift_en & piso_msb;
      rem_valid_q <= last_bit;
      if (last_bit) begin
        rem_out_q  <= rem_in;
        word_out_q <= word_q;
        rem_err_q  <= (rem_in == REM_ILLEGAL);
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign word_clr  = word_clr_q;
  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign rem_valid = rem_valid_q;
  assign rem_out   = rem_out_q;
  assign word_out  = word_out_q;
  assign rem_err   = rem_err_q;

endmodule

// File: tb/tb_word_bit_serializer.sv
// Directed bench: serializer driving a behavioural mod-3 remainder FSM, hand-computed results.
module tb_word_bit_serializer;
  import rem_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready, word_clr, bit_out, bit_valid;
  logic [1:0] rem_in;
  logic       rem_valid;
  logic [1:0] rem_out;
  logic [7:0] word_out;
  logic       rem_err;

  int n_checks = 0;
  int n_errors = 0;

  word_bit_serializer #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .word_clr  (word_clr),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .rem_in    (rem_in),
    .rem_valid (rem_valid),
    .rem_out   (rem_out),
    .word_out  (word_out),
    .rem_err   (rem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream remainder FSM stand-in: r <= (2r + x) mod 3, Mealy output is the next remainder.
  logic [1:0] r3_q, r3_next;
  logic       force_illegal;

  function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic x);
    int v;
    v = 2 * int'(r) + int'(x);
    return 2'(v % 3);
  endfunction

  always_comb r3_next = mod3_step(r3_q, bit_out);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r3_q <= 2'b00;
    else if (word_clr) r3_q <= 2'b00;
    else               r3_q <= r3_next;
  end

  assign rem_in = force_illegal ? REM_ILLEGAL : r3_next;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_word(input logic [7:0] w, input logic [1:0] exp_rem, input logic exp_err,
                          input bit noise, input bit force_ill);
    check("ready_before", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
    check("clr_pulse", 32'(word_clr), 1);
    check("clr_bit_valid", 32'(bit_valid), 0);
    check("clr_bit_out", 32'(bit_out), 0);
    check("ready_low", 32'(in_ready), 0);
    if (noise) begin
      in_valid = 1'b1;
      in_data  = ~w;
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      in_valid = 1'b0;
      if (noise && i == 3) begin
        in_valid = 1'b1;
        in_data  = 8'h55;
      end
      check("bit_valid", 32'(bit_valid), 1);
      check("bit_out", 32'(bit_out), 32'(w[7-i]));
      check("clr_low", 32'(word_clr), 0);
      check("no_early_rem_valid", 32'(rem_valid), 0);
      if (force_ill && i == 7) force_illegal = 1'b1;
    end
    tick();
    force_illegal = 1'b0;
    check("rem_valid", 32'(rem_valid), 1);
    check("rem_out", 32'(rem_out), 32'(exp_rem));
    check("word_out", 32'(word_out), 32'(w));
    check("rem_err", 32'(rem_err), 32'(exp_err));
    check("ready_back", 32'(in_ready), 1);
    check("bit_valid_off", 32'(bit_valid), 0);
    $display("word %0d -> rem %0d err %0d", word_out, rem_out, rem_err);
  endtask

  logic [7:0] b2b_w   [3];
  logic [1:0] b2b_rem [3];

  initial begin
    b2b_w   = '{8'd200, 8'd255, 8'd7};
    b2b_rem = '{REM2, REM0, REM1};
    reset_n       = 1'b0;
    in_valid      = 1'b0;
    in_data       = 8'h00;
    force_illegal = 1'b0;

    // Reset state
    #2;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_word_clr", 32'(word_clr), 0);
    check("rst_bit_valid", 32'(bit_valid), 0);
    check("rst_rem_valid", 32'(rem_valid), 0);
    check("rst_results", 32'({rem_out, word_out, rem_err}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("ready_after_release", 32'(in_ready), 1);

    // Test 1: 9 mod 3 = 0
    run_word(8'd9, REM0, 1'b0, 1'b0, 1'b0);

    // Test 6: result held while idle
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_rem_valid", 32'(rem_valid), 0);
      check("hold_rem_out", 32'(rem_out), 32'(REM0));
      check("hold_word_out", 32'(word_out), 9);
    end

    // Test 2: back-to-back with in_valid held high, one accept every 10 cycles
    in_valid = 1'b1;
    in_data  = b2b_w[0];
    for (int k = 0; k < 3; k++) begin
      check("b2b_ready", 32'(in_ready), 1);
      tick();
      if (k < 2) in_data = b2b_w[k+1];
      else begin
        in_valid = 1'b0;
        in_data  = 8'h00;
      end
      check("b2b_clr", 32'(word_clr), 1);
      for (int j = 0; j < 8; j++) begin
        tick();
        check("b2b_ready_low", 32'(in_ready), 0);
        check("b2b_no_rem_valid", 32'(rem_valid), 0);
      end
      tick();
      check("b2b_rem_valid", 32'(rem_valid), 1);
      check("b2b_rem_out", 32'(rem_out), 32'(b2b_rem[k]));
      check("b2b_word_out", 32'(word_out), 32'(b2b_w[k]));
      $display("word %0d -> rem %0d err %0d", word_out, rem_out, rem_err);
    end

    // Test 3: in_valid noise while busy is ignored; 100 mod 3 = 1
    tick();
    run_word(8'd100, REM1, 1'b0, 1'b1, 1'b0);
    tick();
    check("noise_no_accept", 32'(word_clr), 0);

    // Test 5: illegal remainder forced at the last-bit edge
    run_word(8'd42, REM_ILLEGAL, 1'b1, 1'b0, 1'b1);
    tick();
    check("err_rem_valid_once", 32'(rem_valid), 0);

    // Test 4: reset during the 4th shift bit (0xB6: bits 1,0,1,1,...)
    in_valid = 1'b1;
    in_data  = 8'hB6;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
    for (int i = 0; i < 4; i++) tick();
    check("abort_pre_bit_valid", 32'(bit_valid), 1);
    check("abort_pre_bit_out", 32'(bit_out), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 0);
    check("abort_bits", 32'({word_clr, bit_out, bit_valid}), 0);
    check("abort_rem_valid", 32'(rem_valid), 0);
    check("abort_results", 32'({rem_out, word_out, rem_err}), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_hold_rem_valid", 32'(rem_valid), 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("abort_ready_again", 32'(in_ready), 1);
    check("abort_still_no_rem_valid", 32'(rem_valid), 0);
    run_word(8'd5, REM2, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
